// File: rtl/fifo_pkg.sv
// fifo_pkg: FIFO controller state encodings and Gray-code helpers shared by both sides.
package fifo_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, FLUSH_WAIT} state_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  // XOR prefix from the MSB down; zero-extended upper bits leave the result unchanged
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/ptr_sync2.sv
// ptr_sync2: two-flop synchronizer for Gray-coded pointers crossing clock domains.
module ptr_sync2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side pointer, status flags and flush handshake.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int AF_MARGIN     = 2,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              flush_req,
  input  logic [ADDR_W:0]   rd_gray_ptr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_gray_ptr,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              flush_done,
  output logic              flush_err
);
  localparam int PW = ADDR_W + 1;
  localparam int CW = $clog2(FLUSH_TIMEOUT);
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_W);
  state_t state, state_nxt;
  logic [PW-1:0] wr_bin, bin_nxt, rd_sync, rd_bin, used, free;
  logic [CW-1:0] cnt;
  logic timeout;
  ptr_sync2 #(.W(PW)) u_sync (.clk(clk), .rst_n(rst_n), .d(rd_gray_ptr), .q(rd_sync));
  assign rd_bin      = PW'(gray2bin(32'(rd_sync)));
  assign bin_nxt     = wr_bin + 1'b1;
  assign used        = wr_bin - rd_bin;
  assign free        = DEPTH - used;
  assign full        = wr_gray_ptr == {~rd_sync[PW-1 -: 2], rd_sync[PW-3:0]};
  assign almost_full = free <= PW'(AF_MARGIN);
  assign wr_en       = wr_req & ~full & (state == RUN);
  assign wr_addr     = wr_bin[ADDR_W-1:0];
  assign timeout     = cnt == CW'(FLUSH_TIMEOUT - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == RUN   ? (flush_req ? FLUSH : RUN) :
                state == FLUSH ? FLUSH_WAIT :
                (rd_sync == '0 || timeout) ? RUN : FLUSH_WAIT;
  end
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RUN;
      wr_bin      <= '0;
      wr_gray_ptr <= '0;
      overflow    <= 1'b0;
      flush_err   <= 1'b0;
      flush_done  <= 1'b0;
      cnt         <= '0;
    end else begin
      state      <= state_nxt;
      flush_done <= state == FLUSH_WAIT && rd_sync == '0;
      cnt        <= state == FLUSH_WAIT ? cnt + 1'b1 : '0;
      if (state == FLUSH_WAIT && rd_sync != '0 && timeout) flush_err <= 1'b1;
      // a flush request wins over a same-cycle write: that write is dropped
      if (state == FLUSH) begin
        wr_bin      <= '0;
        wr_gray_ptr <= '0;
        overflow    <= 1'b0;
      end else if (wr_en && !flush_req) begin
        wr_bin      <= bin_nxt;
        wr_gray_ptr <= PW'(bin2gray(32'(bin_nxt)));
      end
      if (state == RUN && wr_req && full) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed checks of fill, sync latency, wrap, flush and timeout.
module tb_fifo_wr_ctrl;
  localparam int AW = 3;
  logic clk = 1'b1, rst_n = 1'b0, wr_req = 1'b0, flush_req = 1'b0;
  logic [AW:0] rd_gray_ptr = '0;
  logic wr_en, full, almost_full, overflow, flush_done, flush_err;
  logic [AW-1:0] wr_addr;
  logic [AW:0] wr_gray_ptr, prev_g, exp_b;
  logic [AW:0] fill_gray [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
  logic done_seen;
  int checks = 0, errors = 0;
  fifo_wr_ctrl #(.ADDR_W(AW), .AF_MARGIN(2), .FLUSH_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .flush_req(flush_req),
    .rd_gray_ptr(rd_gray_ptr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_gray_ptr(wr_gray_ptr), .full(full), .almost_full(almost_full),
    .overflow(overflow), .flush_done(flush_done), .flush_err(flush_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_gray", wr_gray_ptr, 0);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", flush_done, 0);
    check("rst_err", flush_err, 0);
    rst_n = 1'b1;
    tick();
    wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fill_en", wr_en, 1);
      check("fill_addr", wr_addr, i);
      tick();
      check("fill_gray", wr_gray_ptr, fill_gray[i]);
      check("fill_af", almost_full, i >= 5);
      check("fill_full", full, i == 7);
    end
    #1 check("ninth_en", wr_en, 0);
    tick();
    check("ninth_ovf", overflow, 1);
    check("ninth_gray", wr_gray_ptr, 12);
    wr_req = 1'b0;
    rd_gray_ptr = 4'd1;
    tick();
    check("sync_edge1_full", full, 1);
    tick();
    check("sync_edge2_full", full, 0);
    wr_req = 1'b1;
    #1;
    check("drain_en", wr_en, 1);
    check("drain_addr", wr_addr, 0);
    tick();
    check("drain_gray", wr_gray_ptr, 13);
    check("drain_full", full, 1);
    check("drain_ovf_sticky", overflow, 1);
    wr_req = 1'b0;
    exp_b = 4'd9;
    rd_gray_ptr = 4'd13;
    tick();
    tick();
    check("wrap_start_full", full, 0);
    for (int i = 0; i < 16; i++) begin
      rd_gray_ptr = exp_b ^ (exp_b >> 1);
      wr_req = 1'b1;
      prev_g = wr_gray_ptr;
      #1 check("wrap_en", wr_en, 1);
      tick();
      exp_b = exp_b + 1'b1;
      check("wrap_gray", wr_gray_ptr, exp_b ^ (exp_b >> 1));
      check("wrap_onebit", $countones(prev_g ^ wr_gray_ptr), 1);
      if (exp_b == 4'd0) check("wrap_prev8", prev_g, 8);
    end
    wr_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_gray_ptr = 4'd11;
    tick();
    tick();
    wr_req = 1'b1;
    repeat (5) tick();
    #1;
    check("pre_flush_addr", wr_addr, 5);
    check("pre_flush_full", full, 1);
    check("pre_flush_en", wr_en, 0);
    tick();
    check("pre_flush_ovf", overflow, 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1 check("flush_en", wr_en, 0);
    tick();
    check("flush_gray", wr_gray_ptr, 0);
    check("flush_addr", wr_addr, 0);
    check("flush_ovf", overflow, 0);
    #1 check("wait_en", wr_en, 0);
    rd_gray_ptr = 4'd0;
    tick();
    check("done_e2", flush_done, 0);
    check("wait_en_e2", wr_en, 0);
    tick();
    check("done_e3", flush_done, 0);
    check("wait_en_e3", wr_en, 0);
    tick();
    check("done_e4", flush_done, 1);
    #1 check("run_en", wr_en, 1);
    tick();
    check("done_e5", flush_done, 0);
    check("post_flush_gray", wr_gray_ptr, 1);
    check("post_flush_err", flush_err, 0);
    wr_req = 1'b0;
    rd_gray_ptr = 4'd3;
    tick();
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    done_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_err_low", flush_err, 0);
      done_seen = done_seen | flush_done;
    end
    tick();
    check("to_err", flush_err, 1);
    done_seen = done_seen | flush_done;
    check("to_no_done", done_seen, 0);
    wr_req = 1'b1;
    #1 check("to_run_en", wr_en, 1);
    tick();
    wr_req = 1'b0;
    tick();
    check("to_err_sticky", flush_err, 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_err", flush_err, 0);
    check("async_gray", wr_gray_ptr, 0);
    check("async_ovf", overflow, 0);
    check("async_done", flush_done, 0);
    check("async_full", full, 0);
    tick();
    rst_n = 1'b1;
    wr_req = 1'b1;
    #1 check("async_run_en", wr_en, 1);
    tick();
    check("async_run_gray", wr_gray_ptr, 1);
    wr_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the async FIFO. It accepts write requests and generates the memory write strobe and address. It owns the write binary/Gray pointer pair and brings the read-domain Gray pointer into the write clock domain. From these it derives full, almost_full and overflow, and it sequences a flush handshake with the read side. It sits between the producer and the dual-port FIFO RAM; its Gray pointer output feeds the read-side controller.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN (legal range 1..depth-1).
FLUSH_TIMEOUT, 64, max cycles in FLUSH_WAIT before flush_err (>=4).

Ports:
clk  in  1  single clock; all flops update on the falling edge.
rst_n  in  1  asynchronous, active-low reset.
wr_req  in  1  producer write request, level, sampled every cycle.
flush_req  in  1  single-cycle flush request pulse.
rd_gray_ptr  in  ADDR_W+1  read pointer (Gray), asynchronous to clk.
wr_en  out  1  RAM write strobe (combinational).
wr_addr  out  ADDR_W  RAM write address = wr_bin[ADDR_W-1:0].
wr_gray_ptr  out  ADDR_W+1  registered Gray write pointer to read domain.
full  out  1  FIFO full (combinational from registers).
almost_full  out  1  free entries <= AF_MARGIN.
overflow  out  1  sticky: write requested while full.
flush_done  out  1  one-cycle pulse on flush completion.
flush_err  out  1  sticky: flush timed out.

Behaviour:
- Reset (rst_n=0, async): state=RUN; wr_bin=0; wr_gray_ptr=0; sync stages=0; overflow=0; flush_err=0; flush_done=0; timeout counter=0. Combinational outputs follow: wr_en=0, full=0, almost_full=0 (when AF_MARGIN<depth).
- Synchronizer: rd_gray_ptr passes through 2 flops to give rd_sync. Latency is 2 clk edges. Only Gray values cross domains.
- rd_bin = Gray-to-binary conversion of rd_sync (XOR prefix from the MSB down).
- full = (wr_gray_ptr == {~rd_sync[ADDR_W:ADDR_W-1], rd_sync[ADDR_W-2:0]}).
- used = (wr_bin - rd_bin) mod 2**(ADDR_W+1). almost_full = (depth - used) <= AF_MARGIN.
- wr_en = wr_req & ~full & (state==RUN).
- On each edge with wr_en=1: wr_bin increments by 1; wr_gray_ptr <= (wr_bin+1) ^ ((wr_bin+1)>>1). The pointer changes exactly one bit per write and wraps from 2**(ADDR_W+1)-1 to 0.
- overflow is set at the edge where wr_req=1 and full=1 in RUN. It is cleared only by reset or by entry to FLUSH.
- States:
  - RUN: normal operation. flush_req=1 moves to FLUSH. A write requested in the same cycle is dropped (wr_en is still computed as 1 that cycle only if not full; the flush takes priority for the pointer update, so that write is lost and not counted).
  - FLUSH: one cycle. wr_bin=0, wr_gray_ptr=0, overflow=0, timeout counter=0, wr_en=0. Next state is FLUSH_WAIT.
  - FLUSH_WAIT: wr_en=0; the counter increments each cycle. If rd_sync==0, go to RUN with flush_done=1 for one cycle. Else if the counter reaches FLUSH_TIMEOUT-1, set flush_err and go to RUN (no flush_done). flush_req is ignored in FLUSH and FLUSH_WAIT.
- flush_err is sticky until reset.
- Reset mid-flush returns to RUN immediately with all values at their reset state.

Decomposition:
- Shared package fifo_pkg: state encodings (RUN, FLUSH, FLUSH_WAIT); bin2gray and gray2bin functions, which the read-side controller reuses.
- One sub-module, ptr_sync2: a parameterised-width two-flop synchronizer with async active-low reset. The read side instantiates it too.

Test Plan:
- Reset values: rst_n low for 3 cycles -> all outputs 0, wr_addr=0, state RUN.
- Fill to full (ADDR_W=3, rd_gray_ptr=0, wr_req held): 8 writes with wr_addr 0..7. wr_gray_ptr sequence 1,3,2,6,7,5,4,12. almost_full rises after write 6 (AF_MARGIN=2). full=1 after write 8. wr_en=0 on the 9th cycle and overflow=1.
- Drain/sync latency: with full=1, drive rd_gray_ptr=1 -> full deasserts exactly 2 edges later. Next write goes to wr_addr=0 and wr_gray_ptr=13.
- Wrap: 16 writes while the read pointer tracks -> wr_gray_ptr returns to 0 after value 8 (binary 15 -> 0). Each transition changes exactly 1 bit (bench checks popcount of the XOR).
- Flush success: flush_req in RUN with wr_bin=5 and overflow=1 -> next cycle pointer=0 and overflow=0. Drive rd_gray_ptr=0 -> flush_done pulses 2-3 cycles later. wr_req is ignored until RUN.
- Flush timeout: FLUSH_TIMEOUT=8 with rd_gray_ptr held at 3 -> flush_err=1 after 8 cycles in FLUSH_WAIT, no flush_done, state RUN. rst_n pulse mid-FLUSH_WAIT clears everything asynchronously.
